// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate vector sequencer: FSM state encoding,
// vector geometry and expected truth tables for common 3-input gates.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gate_seq_state_t;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;

  localparam logic [7:0] NAND3_TABLE = 8'h7F;
  localparam logic [7:0] AND3_TABLE  = 8'h80;
  localparam logic [7:0] OR3_TABLE   = 8'hFE;
  localparam logic [7:0] NOR3_TABLE  = 8'h01;
  localparam logic [7:0] XOR3_TABLE  = 8'h96;

  // Hold counter width; never narrower than one bit.
  function automatic int hold_cnt_w(input int hold_cycles);
    if (hold_cycles <= 2) begin
      return 1;
    end else begin
      return $clog2(hold_cycles);
    end
  endfunction

endpackage

// File: rtl/gate_seq_hold_timer.sv
// Per-vector hold timer: counts 0..HOLD_CYCLES-1 while enabled, wrapping to 0,
// and flags the final hold cycle so the sequencer knows when to sample y.
module gate_seq_hold_timer
  import gate_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CNT_W = hold_cnt_w(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] hold_r;

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= '0;
    end else if (clr) begin
      hold_r <= '0;
    end else if (en) begin
      if (hold_r == LAST_VAL) begin
        hold_r <= '0;
      end else begin
        hold_r <= hold_r + CNT_W'(1);
      end
    end else begin
      hold_r <= hold_r;
    end
  end

  assign last = (hold_r == LAST_VAL);

endmodule

// File: rtl/gate_vector_sequencer.sv
// Clocked stimulus/response sweep of a 3-input gate against EXPECT_TABLE.
// Optional GATE_SEQ_FIRST_FAIL_EN adds first_fail_valid/first_fail_vec outputs.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int         HOLD_CYCLES  = 10,
  parameter logic [7:0] EXPECT_TABLE = NAND3_TABLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             y,
  output logic [VEC_W-1:0] vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_count
`ifdef GATE_SEQ_FIRST_FAIL_EN
  ,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
`endif
);

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  localparam logic [3:0]       ERR_MAX  = 4'(NUM_VEC);

  gate_seq_state_t  state_r, state_s;
  logic [VEC_W-1:0] vec_r, vec_s;
  logic [3:0]       err_r, err_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic             hold_clr_s, hold_en_s, hold_last_s;
  logic             expect_s, mismatch_s;
`ifdef GATE_SEQ_FIRST_FAIL_EN
  logic             ffv_r, ffv_s;
  logic [VEC_W-1:0] ffvec_r, ffvec_s;
`endif

  gate_seq_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk (clk),
    .rst (rst),
    .clr (hold_clr_s),
    .en  (hold_en_s),
    .last(hold_last_s)
  );

  assign expect_s   = EXPECT_TABLE[vec_r];
  // Case-inequality so an X/Z gate output is scored as a failure.
  assign mismatch_s = (y !== expect_s);

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_s    = state_r;
    vec_s      = vec_r;
    err_s      = err_r;
    busy_s     = busy_r;
    done_s     = done_r;
    pass_s     = pass_r;
    hold_clr_s = 1'b1;
    hold_en_s  = 1'b0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
    ffv_s      = ffv_r;
    ffvec_s    = ffvec_r;
`endif
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = RUN;
          vec_s   = '0;
          err_s   = 4'd0;
          busy_s  = 1'b1;
          done_s  = 1'b0;
          pass_s  = 1'b0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
          ffv_s   = 1'b0;
          ffvec_s = '0;
`endif
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        hold_clr_s = 1'b0;
        hold_en_s  = 1'b1;
        if (hold_last_s) begin
          if (mismatch_s && (err_r != ERR_MAX)) begin
            err_s = err_r + 4'd1;
          end else begin
            err_s = err_r;
          end
`ifdef GATE_SEQ_FIRST_FAIL_EN
          if (mismatch_s && !ffv_r) begin
            ffv_s   = 1'b1;
            ffvec_s = vec_r;
          end else begin
            ffv_s   = ffv_r;
          end
`endif
          if (vec_r == LAST_VEC) begin
            state_s = DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = (err_s == 4'd0);
          end else begin
            vec_s   = vec_r + VEC_W'(1);
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
        vec_s   = '0;
        err_s   = 4'd0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      vec_r   <= '0;
      err_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
      ffv_r   <= 1'b0;
      ffvec_r <= '0;
`endif
    end else begin
      state_r <= state_s;
      vec_r   <= vec_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
`ifdef GATE_SEQ_FIRST_FAIL_EN
      ffv_r   <= ffv_s;
      ffvec_r <= ffvec_s;
`endif
    end
  end

  assign a         = vec_r[2];
  assign b         = vec_r[1];
  assign c         = vec_r[0];
  assign vec_idx   = vec_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_r;
`ifdef GATE_SEQ_FIRST_FAIL_EN
  assign first_fail_valid = ffv_r;
  assign first_fail_vec   = ffvec_r;
`endif

endmodule
